// File: rtl/vc_pkg.sv
// ============================================================================
//  Module      : vc_pkg
//  Description : Shared constants and FSM encoding for the VC schedulers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vc_pkg;

    localparam int NUM_VC           = 4;
    localparam int c_default_weight = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_XFER  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ERROR = 3'd4
    } vc_state_t;

endpackage : vc_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Rotating-priority finder; first requester after i_ptr wins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import vc_pkg::*;
(
    input  logic [NUM_VC-1:0] i_req,
    input  logic [1:0]        i_ptr,
    output logic [1:0]        o_winner,
    output logic              o_found
);

    // Scan farthest-first so the nearest requester (ptr+1) overwrites last.
    always_comb begin
        o_winner = i_ptr;
        o_found  = 1'b0;
        for (int k = NUM_VC; k >= 1; k--) begin
            if (i_req[i_ptr + 2'(k)]) begin
                o_winner = i_ptr + 2'(k);
                o_found  = 1'b1;
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/vc_arbiter.sv
// ============================================================================
//  Module      : vc_arbiter
//  Description : Weighted round-robin drain of four VC FIFOs into one link.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_arbiter
    import vc_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int WGT_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [NUM_VC*WGT_W-1:0]  cfg_weight,
    input  logic                     enable,
    input  logic [NUM_VC-1:0]        fifo_empty,
    input  logic [NUM_VC*DATA_W-1:0] fifo_data,
    input  logic                     out_pause,
    input  logic                     out_full,
    output logic [NUM_VC-1:0]        pop,
    output logic                     out_push,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               grant_id,
    output logic                     busy,
    output logic                     error
);

    localparam logic [WGT_W-1:0] c_wgt_default = WGT_W'(c_default_weight);
    localparam logic [WGT_W-1:0] c_wgt_one     = WGT_W'(1);

    vc_state_t          r_state;
    logic [1:0]         r_grant;
    logic [1:0]         r_grant_d;
    logic [1:0]         r_ptr;
    logic [WGT_W-1:0]   r_credit;
    logic [WGT_W-1:0]   r_weight [NUM_VC];
    logic               r_out_push;
    logic [DATA_W-1:0]  r_out_hold;
    logic               r_error;

    logic [DATA_W-1:0]  w_fifo_word [NUM_VC];
    logic [WGT_W-1:0]   w_cfg_wgt   [NUM_VC];
    logic [NUM_VC-1:0]  w_req;
    logic [1:0]         w_pick;
    logic               w_found;
    logic               w_overflow;
    logic               w_gnt_empty;
    logic               w_pop_ok;
    logic [WGT_W-1:0]   w_credit_inc;
    logic               w_burst_done;
    logic [DATA_W-1:0]  w_out_data;

    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
        assign w_fifo_word[gi] = fifo_data[gi*DATA_W +: DATA_W];
        assign w_cfg_wgt[gi]   = (cfg_weight[gi*WGT_W +: WGT_W] == '0)
                               ? c_wgt_one : cfg_weight[gi*WGT_W +: WGT_W];
    end

    assign w_req = ~fifo_empty;

    rr_pick u_rr_pick (
        .i_req    (w_req),
        .i_ptr    (r_ptr),
        .o_winner (w_pick),
        .o_found  (w_found)
    );

    assign w_overflow   = r_out_push && out_full;
    assign w_gnt_empty  = fifo_empty[r_grant];
    // Reset, init and a fresh overflow all suppress the pop in their own cycle.
    assign w_pop_ok     = (r_state == ST_XFER) && !reset && !init && !w_overflow
                       && !w_gnt_empty && !out_pause && enable;
    assign pop          = w_pop_ok ? (NUM_VC'(1) << r_grant) : '0;
    assign w_credit_inc = r_credit + c_wgt_one;
    assign w_burst_done = (w_credit_inc == r_weight[r_grant]);

    // The FIFO word lands the cycle after the pop, in step with out_push;
    // the holding register keeps the last word visible between pushes.
    assign w_out_data = r_out_push ? w_fifo_word[r_grant_d] : r_out_hold;

    assign out_push = r_out_push;
    assign out_data = w_out_data;
    assign grant_id = r_grant;
    assign error    = r_error;
    assign busy     = (r_state == ST_ARB) || (r_state == ST_XFER) || (r_state == ST_PAUSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 2'd0;
            r_grant_d  <= 2'd0;
            r_ptr      <= 2'd3;
            r_credit   <= '0;
            r_out_push <= 1'b0;
            r_out_hold <= '0;
            r_error    <= 1'b0;
            for (int i = 0; i < NUM_VC; i++) begin
                r_weight[i] <= c_wgt_default;
            end
        end else begin
            r_grant_d  <= r_grant;
            r_out_push <= |pop;
            r_out_hold <= w_out_data;
            if (w_overflow) begin
                r_error <= 1'b1;
            end
            if (init) begin
                r_credit <= '0;
                r_ptr    <= 2'd3;
                for (int i = 0; i < NUM_VC; i++) begin
                    r_weight[i] <= w_cfg_wgt[i];
                end
            end

            // Overflow is terminal: only reset leaves ERROR, init does not.
            if (w_overflow || (r_state == ST_ERROR)) begin
                r_state <= ST_ERROR;
            end else if (init) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (enable && (|w_req)) begin
                            r_state <= ST_ARB;
                        end
                    end
                    ST_ARB: begin
                        if (enable && w_found) begin
                            r_grant  <= w_pick;
                            r_credit <= '0;
                            r_state  <= ST_XFER;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_XFER: begin
                        if (out_pause) begin
                            r_state <= ST_PAUSE;
                        end else begin
                            if (|pop) begin
                                r_credit <= w_credit_inc;
                            end
                            if (((|pop) && w_burst_done) || w_gnt_empty || !enable) begin
                                r_ptr   <= r_grant;
                                r_state <= ST_ARB;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (!out_pause) begin
                            if (!w_gnt_empty) begin
                                r_state <= ST_XFER;
                            end else begin
                                r_ptr   <= r_grant;
                                r_state <= ST_ARB;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : vc_arbiter

`default_nettype wire
